// File: rtl/bus_arbiter_if.sv
// Bus bundle between the two CPU-side requesters (ibus, dbus), the
// shared memory port and the arbiter. The arbiter uses the slave view.
interface bus_arbiter_if;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_addr_ok;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;

   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic [2:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_addr_ok;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;

   logic        mreq_valid;
   logic        mreq_is_write;
   logic [63:0] mreq_addr;
   logic [2:0]  mreq_size;
   logic [7:0]  mreq_strobe;
   logic [63:0] mreq_data;
   logic        mresp_ready;
   logic [63:0] mresp_data;

   modport slave (
      input  ireq_valid, ireq_addr,
      input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      input  mresp_ready, mresp_data,
      output iresp_addr_ok, iresp_data_ok, iresp_data,
      output dresp_addr_ok, dresp_data_ok, dresp_data,
      output mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data
   );

   modport master (
      output ireq_valid, ireq_addr,
      output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      output mresp_ready, mresp_data,
      input  iresp_addr_ok, iresp_data_ok, iresp_data,
      input  dresp_addr_ok, dresp_data_ok, dresp_data,
      input  mreq_valid, mreq_is_write, mreq_addr, mreq_size, mreq_strobe, mreq_data
   );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester arbiter (instruction fetch / data) in front of a single
// memory port. One transaction at a time: grant in IDLE, hold the latched
// request on the memory port in BUSY, hand the response back in RESP.
module bus_arbiter #(
   parameter bit DBUS_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        grant_i;
   logic        grant_d;
   logic        in_busy;
   logic        in_resp;

   // Latched transaction; owner 0 = ibus, 1 = dbus.
   logic        owner;
   logic        is_write;
   logic [63:0] addr;
   logic [2:0]  size;
   logic [7:0]  strobe;
   logic [63:0] wdata;
   logic [63:0] rdata;

   // Next-state and grant decision; grants only happen from IDLE.
   always_comb begin
      state_next = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.dreq_valid && (DBUS_FIRST || !bus.ireq_valid))
               grant_d = 1'b1;
            else if (bus.ireq_valid)
               grant_i = 1'b1;
            if (grant_i || grant_d)
               state_next = BUSY;
         end
         BUSY: begin
            if (bus.mresp_ready)
               state_next = RESP;
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Capture the granted request and the memory read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner    <= 1'b0;
         is_write <= 1'b0;
         addr     <= '0;
         size     <= '0;
         strobe   <= '0;
         wdata    <= '0;
         rdata    <= '0;
      end else begin
         if (grant_d) begin
            owner    <= 1'b1;
            is_write <= |bus.dreq_strobe;
            addr     <= bus.dreq_addr;
            size     <= bus.dreq_size;
            strobe   <= bus.dreq_strobe;
            wdata    <= bus.dreq_data;
         end else if (grant_i) begin
            // Fetches are always 4-byte reads.
            owner    <= 1'b0;
            is_write <= 1'b0;
            addr     <= bus.ireq_addr;
            size     <= 3'b010;
            strobe   <= '0;
            wdata    <= '0;
         end
         if (state == BUSY && bus.mresp_ready)
            rdata <= bus.mresp_data;
      end
   end

   assign in_busy = (state == BUSY);
   assign in_resp = (state == RESP);

   // Memory port shows only registered values, and only while BUSY.
   assign bus.mreq_valid    = in_busy;
   assign bus.mreq_is_write = in_busy & is_write;
   assign bus.mreq_addr     = in_busy ? addr   : '0;
   assign bus.mreq_size     = in_busy ? size   : '0;
   assign bus.mreq_strobe   = in_busy ? strobe : '0;
   assign bus.mreq_data     = in_busy ? wdata  : '0;

   assign bus.iresp_addr_ok = grant_i;
   assign bus.dresp_addr_ok = grant_d;

   // A requester that dropped its valid before RESP gets no data_ok.
   assign bus.iresp_data_ok = in_resp & ~owner & bus.ireq_valid;
   assign bus.dresp_data_ok = in_resp &  owner & bus.dreq_valid;

   // The fetch word is picked from the 64-bit line by address bit 2.
   assign bus.iresp_data = !bus.iresp_data_ok ? '0 :
                           (addr[2] ? rdata[63:32] : rdata[31:0]);
   assign bus.dresp_data = bus.dresp_data_ok ? rdata : '0;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter DBUS_FIRST, default 1: when 1, dbus wins simultaneous requests; when 0, ibus wins.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ireq_valid  input  1  instruction fetch request, held high until iresp_data_ok.
REQ-006 ireq_addr  input  64  fetch address, 4-byte aligned.
REQ-007 iresp_addr_ok  output  1  fetch request granted this cycle.
REQ-008 iresp_data_ok  output  1  fetch data valid, single-cycle pulse.
REQ-009 iresp_data  output  32  fetched instruction.
REQ-010 dreq_valid  input  1  data request, held high until dresp_data_ok.
REQ-011 dreq_addr  input  64  data address.
REQ-012 dreq_size  input  3  access size code (byte/half/word/dword).
REQ-013 dreq_strobe  input  8  byte write enables; all-zero means read.
REQ-014 dreq_data  input  64  write data, lane-aligned.
REQ-015 dresp_addr_ok  output  1  data request granted this cycle.
REQ-016 dresp_data_ok  output  1  data response valid, single-cycle pulse.
REQ-017 dresp_data  output  64  read data, full 64-bit line.
REQ-018 mreq_valid  output  1  shared memory port request.
REQ-019 mreq_is_write  output  1  1 = write transaction.
REQ-020 mreq_addr  output  64  memory address.
REQ-021 mreq_size  output  3  access size; 3'b010 for fetches.
REQ-022 mreq_strobe  output  8  byte enables; zero for reads.
REQ-023 mreq_data  output  64  write data.
REQ-024 mresp_ready  input  1  memory completes the transaction this cycle.
REQ-025 mresp_data  input  64  read data, valid when mresp_ready=1.

Function
REQ-026 FSM: IDLE, BUSY, RESP; 1-bit owner register (0 = ibus, 1 = dbus).
REQ-027 IDLE, no valid request: stay in IDLE; all outputs 0.
REQ-028 IDLE with a valid request: grant it (both valid: DBUS_FIRST decides); pulse that side's addr_ok for this cycle only; latch addr, size, strobe, data and owner; go to BUSY.
REQ-029 BUSY: mreq_valid=1; mreq_* driven only from the latched registers, stable until mresp_ready.
REQ-030 BUSY with mresp_ready=1: latch mresp_data; go to RESP. Otherwise stay in BUSY with no timeout.
REQ-031 RESP: pulse owner's data_ok for exactly one cycle; mreq_valid=0; go to IDLE.
REQ-032 Fetch latched: mreq_is_write=0, mreq_size=3'b010, mreq_strobe=0.
REQ-033 Data latched: mreq_is_write = |dreq_strobe; size and strobe passed through unchanged.
REQ-034 iresp_data = latched data[63:32] when latched addr[2]=1, else [31:0]; dresp_data = full 64 bits.
REQ-035 Latency: grant at cycle N; mreq_valid first high at N+1; mresp_ready at M≥N+1 gives data_ok at M+1; a new grant is possible at M+2 at the earliest.
REQ-036 Requester valid dropping during BUSY or RESP: the transaction still completes on mreq; data_ok is suppressed if the owner's valid is low in RESP.
REQ-037 Non-owner requests are never granted while the FSM is not in IDLE; its addr_ok and data_ok stay 0.
REQ-038 Outputs: data_ok, data and addr_ok are 0 whenever not asserted per REQ-028/031; no output ever depends combinationally on mresp_*.

Reset
REQ-039 reset=1 at a clock edge: FSM to IDLE, owner=0, latched registers cleared; all outputs 0 the next cycle. This includes reset mid-BUSY: the memory transaction is abandoned with no data_ok.
REQ-040 A request valid in the first cycle after reset deasserts is granted in that cycle.

Verification
REQ-041 ireq_valid=1, addr=0x8000_0004; mresp_ready 3 cycles after grant with data=0x1111_2222_3333_4444 -> iresp_data_ok one cycle, iresp_data=0x1111_2222.
REQ-042 ireq and dreq (read 0x8000_1000) raised in the same cycle, DBUS_FIRST=1 -> dbus granted first; ibus granted 2 cycles after dresp_data_ok's mresp_ready cycle.
REQ-043 dreq write, strobe=0x0F, data=0xAABB -> mreq_is_write=1, mreq_strobe=0x0F, mreq_data=0xAABB held constant through 5 stalled cycles.
REQ-044 dreq_valid dropped during BUSY -> mreq completes; dresp_data_ok stays 0; FSM returns to IDLE.
REQ-045 reset asserted in BUSY -> mreq_valid=0 next cycle; no data_ok; next ireq granted immediately.
REQ-046 DBUS_FIRST=0, simultaneous requests -> ibus granted first.
